// File: rtl/nibble_stream_checker_pkg.sv
// Shared types and helpers for the nibble stream checker: FSM state encoding,
// nibble width and a wrap-around nibble adder.
package nibble_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    // Sum truncated to a nibble, so 15 + 1 wraps to 0.
    function automatic logic [NIBBLE_W-1:0] nib_add(input logic [NIBBLE_W-1:0] a,
                                                    input logic [NIBBLE_W-1:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/nibble_stream_checker_if.sv
// Stream and status bundle between the stream source/observer and the checker.
interface nibble_stream_checker_if
    import nibble_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    logic [NIBBLE_W-1:0] data;
    logic                enable;
    logic                locked;
    logic                mismatch;
    logic [NIBBLE_W-1:0] expected;
    logic [CNT_W-1:0]    good_count;
    logic [CNT_W-1:0]    err_count;

    // Source/observer side: drives the stream, watches the status.
    modport master (
        output data,
        output enable,
        input  locked,
        input  mismatch,
        input  expected,
        input  good_count,
        input  err_count
    );

    // Checker side.
    modport slave (
        input  data,
        input  enable,
        output locked,
        output mismatch,
        output expected,
        output good_count,
        output err_count
    );

endinterface

// File: rtl/nibble_stream_checker_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         inc_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign q_o = count_q;

endmodule

// File: rtl/nibble_stream_checker.sv
// Receive-side checker for a 4-bit stepping counter stream: locks onto the sequence,
// then flags every sample that is not the previous sample plus STEP.
module nibble_stream_checker
    import nibble_pkg::*;
#(
    parameter int STEP       = 1,
    parameter int LOCK_COUNT = 3,
    parameter int LOSS_COUNT = 2,
    parameter int CNT_W      = 16
) (
    input  logic                    clock,
    input  logic                    clear,
    nibble_stream_checker_if.slave  bus
);

    localparam logic [NIBBLE_W-1:0] STEP_N = NIBBLE_W'(STEP);
    localparam logic [3:0]          LOCK_N = 4'(LOCK_COUNT);
    localparam logic [3:0]          LOSS_N = 4'(LOSS_COUNT);

    state_e              state_q,    state_d;
    logic [3:0]          run_q,      run_d;
    logic [NIBBLE_W-1:0] expected_q, expected_d;
    logic                mismatch_q, mismatch_d;
    logic                good_inc;
    logic                err_inc;
    logic                hit;
    logic [CNT_W-1:0]    good_cnt;
    logic [CNT_W-1:0]    err_cnt;

    assign hit = (bus.data == expected_q);

    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        expected_d = expected_q;
        mismatch_d = 1'b0;
        good_inc   = 1'b0;
        err_inc    = 1'b0;
        if (bus.enable) begin
            // Prediction always follows the received value so a single glitch resyncs.
            expected_d = nib_add(bus.data, STEP_N);
            unique case (state_q)
                IDLE: begin
                    state_d = ACQUIRE;
                    run_d   = '0;
                end
                ACQUIRE: begin
                    if (!hit) begin
                        run_d = '0;
                    end else if (run_q + 4'd1 == LOCK_N) begin
                        state_d = LOCKED;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + 4'd1;
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        good_inc = 1'b1;
                        run_d    = '0;
                    end else begin
                        mismatch_d = 1'b1;
                        err_inc    = 1'b1;
                        if (run_q + 4'd1 == LOSS_N) begin
                            state_d = ACQUIRE;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    run_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= IDLE;
            run_q      <= '0;
            expected_q <= '0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            expected_q <= expected_d;
            mismatch_q <= mismatch_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_good_cnt (
        .clock (clock),
        .clear (clear),
        .inc_i (good_inc),
        .q_o   (good_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clock (clock),
        .clear (clear),
        .inc_i (err_inc),
        .q_o   (err_cnt)
    );

    assign bus.locked     = (state_q == LOCKED);
    assign bus.mismatch   = mismatch_q;
    assign bus.expected   = expected_q;
    assign bus.good_count = good_cnt;
    assign bus.err_count  = err_cnt;

endmodule

// File: tb/tb_nibble_stream_checker.sv
// Directed bench for nibble_stream_checker: a behavioural model pushes the expected
// status per sample into a scoreboard, popped and compared one cycle later.
module tb_nibble_stream_checker;

    localparam int STEP       = 1;
    localparam int LOCK_COUNT = 3;
    localparam int LOSS_COUNT = 2;

    localparam int S_IDLE = 0;
    localparam int S_ACQ  = 1;
    localparam int S_LOCK = 2;

    logic clock = 1'b0;
    logic clear = 1'b1;

    always #5 clock = ~clock;

    nibble_stream_checker_if #(.CNT_W(16)) u_if  ();
    nibble_stream_checker_if #(.CNT_W(2))  u_if2 ();

    nibble_stream_checker #(
        .STEP(STEP), .LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .CNT_W(16)
    ) dut (
        .clock (clock),
        .clear (clear),
        .bus   (u_if.slave)
    );

    nibble_stream_checker #(
        .STEP(STEP), .LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .CNT_W(2)
    ) dut2 (
        .clock (clock),
        .clear (clear),
        .bus   (u_if2.slave)
    );

    typedef struct {
        logic        locked;
        logic        mm;
        logic [3:0]  exp_nib;
        logic [15:0] good;
        logic [15:0] err;
        logic [1:0]  good2;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    int         m_st = S_IDLE;
    int         m_run = 0;
    logic [3:0] m_exp = 4'd0;
    int         m_good = 0;
    int         m_err = 0;
    int         m_good2 = 0;
    logic       m_mm = 1'b0;

    task automatic check(input string tag, input string name,
                         input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, name, obs, req);
        end
    endtask

    task automatic model_step(input logic [3:0] d, input logic en, input logic clr);
        logic hit;
        hit = (d == m_exp);
        if (clr) begin
            m_st = S_IDLE; m_run = 0; m_exp = 4'd0;
            m_good = 0; m_err = 0; m_good2 = 0; m_mm = 1'b0;
        end else if (!en) begin
            m_mm = 1'b0;
        end else begin
            m_mm = 1'b0;
            case (m_st)
                S_IDLE: begin
                    m_st  = S_ACQ;
                    m_run = 0;
                end
                S_ACQ: begin
                    if (!hit) m_run = 0;
                    else if (m_run + 1 == LOCK_COUNT) begin m_st = S_LOCK; m_run = 0; end
                    else m_run = m_run + 1;
                end
                default: begin
                    if (hit) begin
                        if (m_good < 65535) m_good = m_good + 1;
                        if (m_good2 < 3) m_good2 = m_good2 + 1;
                        m_run = 0;
                    end else begin
                        m_mm = 1'b1;
                        if (m_err < 65535) m_err = m_err + 1;
                        if (m_run + 1 == LOSS_COUNT) begin m_st = S_ACQ; m_run = 0; end
                        else m_run = m_run + 1;
                    end
                end
            endcase
            m_exp = 4'((int'(d) + STEP) % 16);
        end
    endtask

    // Drive one sample, predict, clock it in, then compare both DUTs against the prediction.
    task automatic cycle(input logic [3:0] d, input logic en, input logic clr, input string tag);
        exp_t e;
        u_if.data    = d;
        u_if.enable  = en;
        u_if2.data   = d;
        u_if2.enable = en;
        clear        = clr;
        model_step(d, en, clr);
        e.locked  = (m_st == S_LOCK);
        e.mm      = m_mm;
        e.exp_nib = m_exp;
        e.good    = 16'(m_good);
        e.err     = 16'(m_err);
        e.good2   = 2'(m_good2);
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check(tag, "locked",     32'(u_if.locked),      32'(e.locked));
        check(tag, "mismatch",   32'(u_if.mismatch),    32'(e.mm));
        check(tag, "expected",   32'(u_if.expected),    32'(e.exp_nib));
        check(tag, "good_count", 32'(u_if.good_count),  32'(e.good));
        check(tag, "err_count",  32'(u_if.err_count),   32'(e.err));
        check(tag, "good2",      32'(u_if2.good_count), 32'(e.good2));
        check(tag, "locked2",    32'(u_if2.locked),     32'(e.locked));
        $display("[%0t] %s data=%h en=%b clr=%b -> locked=%b mm=%b exp=%h good=%0d err=%0d good2=%0d",
                 $time, tag, d, en, clr, u_if.locked, u_if.mismatch, u_if.expected,
                 u_if.good_count, u_if.err_count, u_if2.good_count);
    endtask

    initial begin
        u_if.data = 4'd0; u_if.enable = 1'b0;
        u_if2.data = 4'd0; u_if2.enable = 1'b0;

        // Reset held for three edges.
        for (int i = 0; i < 3; i++) cycle(4'd0, 1'b1, 1'b1, "reset");
        check("reset", "locked_const",   32'(u_if.locked),     32'd0);
        check("reset", "err_const",      32'(u_if.err_count),  32'd0);

        // 1: clean count with wrap; lock on the fourth sample.
        for (int k = 0; k < 20; k++) begin
            cycle(4'(k % 16), 1'b1, 1'b0, "count");
            if (k == 2) check("count", "not_yet_locked", 32'(u_if.locked), 32'd0);
            if (k == 3) check("count", "locked_at_4th",  32'(u_if.locked), 32'd1);
        end
        check("count", "good_after_wrap", 32'(u_if.good_count), 32'd16);
        check("count", "good2_saturated", 32'(u_if2.good_count), 32'd3);

        // 2: single wrong value, then the stream resumes from the received value.
        cycle(4'd4, 1'b1, 1'b0, "glitch");
        cycle(4'd5, 1'b1, 1'b0, "glitch");
        cycle(4'd6, 1'b1, 1'b0, "glitch");
        cycle(4'd5, 1'b1, 1'b0, "glitch_bad");
        check("glitch", "pulse",      32'(u_if.mismatch),  32'd1);
        check("glitch", "err_one",    32'(u_if.err_count), 32'd1);
        cycle(4'd6, 1'b1, 1'b0, "glitch");
        check("glitch", "pulse_gone", 32'(u_if.mismatch),  32'd0);
        check("glitch", "still_lock", 32'(u_if.locked),    32'd1);
        cycle(4'd7, 1'b1, 1'b0, "glitch");
        cycle(4'd8, 1'b1, 1'b0, "glitch");

        // 3: stuck data drops lock after two mismatches; counting relocks.
        for (int i = 0; i < 4; i++) begin
            cycle(4'd8, 1'b1, 1'b0, "stuck");
            if (i == 1) check("stuck", "lock_lost", 32'(u_if.locked), 32'd0);
        end
        check("stuck", "err_three", 32'(u_if.err_count), 32'd3);
        cycle(4'd9,  1'b1, 1'b0, "relock");
        cycle(4'd10, 1'b1, 1'b0, "relock");
        cycle(4'd11, 1'b1, 1'b0, "relock");
        check("relock", "relocked", 32'(u_if.locked), 32'd1);

        // 4: single-edge clear while locked.
        cycle(4'd12, 1'b1, 1'b1, "clear");
        check("clear", "expected_zero", 32'(u_if.expected),   32'd0);
        check("clear", "good_zero",     32'(u_if.good_count), 32'd0);

        // 5: relock, freeze for five cycles, resume with the old sequence.
        for (int k = 0; k < 6; k++) cycle(4'(k), 1'b1, 1'b0, "prefreeze");
        for (int k = 6; k < 11; k++) cycle(4'(k), 1'b0, 1'b0, "freeze");
        check("freeze", "expected_held", 32'(u_if.expected),   32'd6);
        check("freeze", "good_held",     32'(u_if.good_count), 32'd2);
        cycle(4'd11, 1'b1, 1'b0, "resume");
        check("resume", "pulse", 32'(u_if.mismatch), 32'd1);
        cycle(4'd12, 1'b1, 1'b0, "resume");
        cycle(4'd13, 1'b1, 1'b0, "resume");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
